// File: rtl/legv8_pkg.sv
// LEGv8 op classes, opcode field constants and field widths shared by the
// instruction encoder and the control decoder.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_ORR  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5,
    OP_MOVZ = 4'd6,
    OP_B    = 4'd7,
    OP_CBZ  = 4'd8,
    OP_LDUR = 4'd9,
    OP_STUR = 4'd10
  } op_e;

  localparam int INST_W    = 32;
  localparam int REG_W     = 5;
  localparam int IMM_W     = 26;
  localparam int HW_W      = 2;
  localparam int ALU_IMM_W = 12;
  localparam int MOV_IMM_W = 16;
  localparam int BR_IMM_W  = 26;
  localparam int CB_IMM_W  = 19;
  localparam int DT_IMM_W  = 9;

  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

endpackage

// File: rtl/inst_pack.sv
// Combinational LEGv8 field packer: op class plus register/immediate fields
// in, 32-bit instruction word and an illegal-op flag out.
module inst_pack
  import legv8_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [REG_W-1:0]  rn_i,
  input  logic [REG_W-1:0]  rm_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [HW_W-1:0]   hw_i,
  output logic [INST_W-1:0] word_o,
  output logic              illegal_o
);

  // Upper immediate bits beyond each format's field are simply dropped.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:  word_o = {OPC_AND, rm_i, 6'b0, rn_i, rd_i};
      OP_ORR:  word_o = {OPC_ORR, rm_i, 6'b0, rn_i, rd_i};
      OP_ADD:  word_o = {OPC_ADD, rm_i, 6'b0, rn_i, rd_i};
      OP_SUB:  word_o = {OPC_SUB, rm_i, 6'b0, rn_i, rd_i};
      OP_ADDI: word_o = {OPC_ADDI, imm_i[ALU_IMM_W-1:0], rn_i, rd_i};
      OP_SUBI: word_o = {OPC_SUBI, imm_i[ALU_IMM_W-1:0], rn_i, rd_i};
      OP_MOVZ: word_o = {OPC_MOVZ, hw_i, imm_i[MOV_IMM_W-1:0], rd_i};
      OP_B:    word_o = {OPC_B, imm_i[BR_IMM_W-1:0]};
      OP_CBZ:  word_o = {OPC_CBZ, imm_i[CB_IMM_W-1:0], rd_i};
      OP_LDUR: word_o = {OPC_LDUR, imm_i[DT_IMM_W-1:0], 2'b00, rn_i, rd_i};
      OP_STUR: word_o = {OPC_STUR, imm_i[DT_IMM_W-1:0], 2'b00, rn_i, rd_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// LEGv8 instruction encoder: accepts instruction descriptions, emits packed
// words tagged with a running byte address through a one-deep output register.
module inst_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  input  logic [1:0]        hw,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       count
);

  logic              valid_q, valid_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [15:0]       count_q, count_d;

  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              accept;
  logic [ADDR_W-1:0] base_addr;

  inst_pack u_pack (
    .op_i      (op),
    .rd_i      (rd),
    .rn_i      (rn),
    .rm_i      (rm),
    .imm_i     (imm),
    .hw_i      (hw),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // A same-cycle load redirects the word being accepted, not the held one.
  assign base_addr = load_addr ? start_addr : addr_q;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    oaddr_d = oaddr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    count_d = count_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
      count_d = count_q + 16'd1;
    end
    if (load_addr) addr_d = start_addr;
    if (accept) begin
      if (pack_illegal) begin
        err_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        word_d  = pack_word;
        oaddr_d = base_addr;
        addr_d  = base_addr + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      oaddr_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      oaddr_q <= oaddr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_addr  = oaddr_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed scenarios plus randomized
// traffic checked against an arithmetic encoding model.
module tb_inst_encoder;

  localparam int ADDR_W = 64;

  logic              CLK = 1'b0;
  logic              resetl;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd, rn, rm;
  logic [25:0]       imm;
  logic [1:0]        hw;
  logic              load_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [15:0]       count;

  inst_encoder #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .hw(hw),
    .load_addr(load_addr), .start_addr(start_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err(err), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                checks   = 0;
  int                failures = 0;
  logic [ADDR_W-1:0] addr_m;
  logic              err_m;
  logic [15:0]       cnt_model;
  logic              rnd_rdy;
  logic              prev_stall;
  logic [31:0]       prev_word;
  logic [ADDR_W-1:0] prev_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference encoding built from field weights (powers of two), not bit slicing.
  function automatic void ref_enc(input int unsigned o, input longint unsigned d,
                                  input longint unsigned n, input longint unsigned m,
                                  input longint unsigned im, input longint unsigned h,
                                  output logic [31:0] w, output logic legal);
    longint unsigned v;
    legal = 1'b1;
    case (o)
      0:  v = 64'h450 * (1 << 21) + m * (1 << 16) + n * 32 + d;
      1:  v = 64'h550 * (1 << 21) + m * (1 << 16) + n * 32 + d;
      2:  v = 64'h458 * (1 << 21) + m * (1 << 16) + n * 32 + d;
      3:  v = 64'h658 * (1 << 21) + m * (1 << 16) + n * 32 + d;
      4:  v = 64'h244 * (1 << 22) + (im % 4096) * 1024 + n * 32 + d;
      5:  v = 64'h344 * (1 << 22) + (im % 4096) * 1024 + n * 32 + d;
      6:  v = 64'h1A5 * (1 << 23) + h * (1 << 21) + (im % 65536) * 32 + d;
      7:  v = 64'h5 * (1 << 26) + (im % (1 << 26));
      8:  v = 64'hB4 * (1 << 24) + (im % (1 << 19)) * 32 + d;
      9:  v = 64'h7C2 * (1 << 21) + (im % 512) * 4096 + n * 32 + d;
      10: v = 64'h7C0 * (1 << 21) + (im % 512) * 4096 + n * 32 + d;
      default: begin v = 0; legal = 1'b0; end
    endcase
    w = v[31:0];
  endfunction

  // Issue one request, wait for acceptance, and record what should come out.
  task automatic send(input int unsigned o, input logic [4:0] d, input logic [4:0] n,
                      input logic [4:0] m, input logic [25:0] im, input logic [1:0] h,
                      input logic ld, input logic [ADDR_W-1:0] sa,
                      input logic use_const, input logic [31:0] cw);
    logic [31:0]       w;
    logic              legal;
    logic [ADDR_W-1:0] base;
    int                guard;
    op = o[3:0]; rd = d; rn = n; rm = m; imm = im; hw = h;
    load_addr = ld; start_addr = sa; in_valid = 1'b1;
    guard = 0;
    @(negedge CLK);
    while (!in_ready) begin
      guard++;
      if (guard > 100) begin
        $display("FAIL accept_timeout actual=0 required=1");
        $fatal(1, "stalled");
      end
      @(posedge CLK); #1;
      if (rnd_rdy) out_ready = ($urandom % 4) != 0;
      @(negedge CLK);
    end
    ref_enc(o, d, n, m, im, h, w, legal);
    base = ld ? sa : addr_m;
    if (legal) begin
      exp_q.push_back('{w: (use_const ? cw : w), a: base});
      addr_m = base + 4;
    end else begin
      addr_m = base;
      err_m  = 1'b1;
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; load_addr = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; load_addr = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
      if (rnd_rdy) out_ready = ($urandom % 4) != 0;
    end
  endtask

  // Monitor: pops the scoreboard on every completed output handshake.
  always @(negedge CLK) begin
    if (!resetl) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'(out_word), 64'(prev_word));
        check("hold_addr", out_addr, prev_addr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_word), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_word", 64'(out_word), 64'(mon_e.w));
          check("out_addr", out_addr, mon_e.a);
        end
        check("count", 64'(count), 64'(cnt_model));
        cnt_model = cnt_model + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_word;
      prev_addr  = out_addr;
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_word"}, 64'(out_word), 64'd0);
    check({tag, "_out_addr"}, out_addr, 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [15:0] cnt_before;
    int unsigned o;
    resetl = 1'b1; in_valid = 1'b0; op = '0; rd = '0; rn = '0; rm = '0;
    imm = '0; hw = '0; load_addr = 1'b0; start_addr = '0; out_ready = 1'b0;
    rnd_rdy = 1'b0; addr_m = '0; err_m = 1'b0; cnt_model = '0; prev_stall = 1'b0;
    prev_word = '0; prev_addr = '0;
    #1 resetl = 1'b0;
    #2 reset_checks("reset");
    @(negedge CLK); @(negedge CLK); resetl = 1'b1;
    @(posedge CLK); #1;

    // ADD with a fresh start address
    out_ready = 1'b1;
    send(2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b1, 64'h100, 1'b1, 32'h8B020023);
    idle(2);

    // ADDI then LDUR back-to-back
    send(4, 5'd1, 5'd0, 5'd0, 26'd5, 2'd0, 1'b1, 64'h100, 1'b1, 32'h91001401);
    send(9, 5'd2, 5'd1, 5'd0, 26'd8, 2'd0, 1'b0, 64'h0, 1'b1, 32'hF8408022);
    check("no_bubble_valid", 64'(out_valid), 64'd1);
    check("no_bubble_word", 64'(out_word), 64'hF8408022);
    idle(2);

    // MOVZ held under back-pressure
    out_ready = 1'b0;
    send(6, 5'd0, 5'd0, 5'd0, 26'hABCD, 2'd1, 1'b0, 64'h0, 1'b1, 32'hD2B579A0);
    cnt_before = cnt_model;
    repeat (3) begin
      @(negedge CLK);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_word", 64'(out_word), 64'hD2B579A0);
      check("stall_count", 64'(count), 64'(cnt_before));
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    idle(2);

    // B with maximal displacement, then an illegal op
    send(7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 1'b0, 64'h0, 1'b1, 32'h17FFFFFF);
    send(12, 5'd4, 5'd5, 5'd6, 26'h123, 2'd0, 1'b0, 64'h0, 1'b0, 32'h0);
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_no_word", 64'(out_valid), 64'd0);
    send(3, 5'd7, 5'd8, 5'd9, 26'd0, 2'd0, 1'b0, 64'h0, 1'b0, 32'h0);
    idle(2);

    // Address wrap, then reset while a word is held
    send(0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0);
    send(1, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0, 1'b0, 64'h0, 1'b0, 32'h0);
    idle(2);
    out_ready = 1'b0;
    send(8, 5'd9, 5'd0, 5'd0, 26'h7FFFF, 2'd0, 1'b0, 64'h0, 1'b0, 32'h0);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 resetl = 1'b0;
    #1 reset_checks("async_reset");
    exp_q.delete();
    addr_m = '0; err_m = 1'b0; cnt_model = '0;
    @(negedge CLK); resetl = 1'b1;
    @(posedge CLK); #1;

    // Randomized traffic
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom % 4) != 0;
      o = (($urandom % 10) == 0) ? (11 + $urandom % 5) : ($urandom % 11);
      send(o, 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom), 2'($urandom),
           (($urandom % 16) == 0), {$urandom, $urandom}, 1'b0, 32'h0);
      if (($urandom % 5) == 0) idle($urandom_range(1, 3));
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    idle(4);
    @(negedge CLK);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("final_err", 64'(err), 64'(err_m));
    check("final_count", 64'(count), 64'(cnt_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter ADDR_W, default 64: width of the instruction address carried with each word.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 resetl  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request carries a valid instruction description.
REQ-005 in_ready  output  1  encoder accepts the request this cycle.
REQ-006 op  input  4  instruction class: 0 AND, 1 ORR, 2 ADD, 3 SUB, 4 ADDI, 5 SUBI, 6 MOVZ, 7 B, 8 CBZ, 9 LDUR, 10 STUR, 11-15 illegal.
REQ-007 rd, rn, rm  input  5 each  destination/transfer, first source and second source register numbers.
REQ-008 imm  input  26  immediate, offset or branch displacement (two's complement where signed).
REQ-009 hw  input  2  MOVZ shift selector.
REQ-010 load_addr  input  1  one-cycle strobe that loads start_addr into the address counter.
REQ-011 start_addr  input  ADDR_W  address for the next emitted word.
REQ-012 out_valid  output  1  out_word/out_addr are valid.
REQ-013 out_ready  input  1  consumer takes the word this cycle.
REQ-014 out_word  output  32  encoded LEGv8 instruction.
REQ-015 out_addr  output  ADDR_W  byte address of out_word.
REQ-016 err  output  1  sticky flag: an illegal op was accepted.
REQ-017 count  output  16  number of words emitted (handshakes completed), wraps at 2^16.

Function
REQ-018 The request handshake completes when in_valid and in_ready are both 1 on a rising CLK edge.
REQ-019 in_ready SHALL equal (!out_valid || out_ready), so one word is held and back-to-back throughput is one word per cycle.
REQ-020 An accepted legal op SHALL appear on out_word with out_valid=1 the cycle after acceptance (latency 1).
REQ-021 R-type (AND/ORR/ADD/SUB): opcode 10001010000 / 10101010000 / 10001011000 / 11001011000 in [31:21], rm [20:16], [15:10]=0, rn [9:5], rd [4:0].
REQ-022 ADDI/SUBI: 1001000100 / 1101000100 in [31:22], imm[11:0] in [21:10], rn [9:5], rd [4:0].
REQ-023 MOVZ: 110100101 in [31:23], hw [22:21], imm[15:0] in [20:5], rd [4:0].
REQ-024 B: 000101 in [31:26], imm[25:0] in [25:0]; CBZ: 10110100 in [31:24], imm[18:0] in [23:5], rd (Rt) in [4:0].
REQ-025 LDUR/STUR: 11111000010 / 11111000000 in [31:21], imm[8:0] in [20:12], [11:10]=00, rn [9:5], rd (Rt) [4:0].
REQ-026 Immediate bits above each field width SHALL be ignored (truncation, no range check).
REQ-027 While out_valid=1 and out_ready=0, out_word, out_addr and out_valid SHALL hold unchanged.
REQ-028 An accepted illegal op SHALL set err, emit no word, leave the address counter and count unchanged, and clear out_valid if the held word drains in the same cycle.
REQ-029 The address counter SHALL advance by 4 on each accepted legal op, wrapping modulo 2^ADDR_W.
REQ-030 load_addr SHALL set the counter to start_addr; if a legal op is accepted in the same cycle, that word takes start_addr and the counter becomes start_addr+4.
REQ-031 load_addr SHALL not alter a word already held on the output.
REQ-032 count SHALL increment on each out_valid && out_ready cycle.

Reset
REQ-033 On resetl=0: out_valid=0, out_word=0, out_addr=0, address counter=0, err=0, count=0, in_ready=1; a held word is discarded, taking effect immediately and asynchronously.

Structure
REQ-034 Op class codes, the eleven opcode field constants and field widths SHALL live in the shared LEGv8 package used by the control decoder.
REQ-035 Field packing SHALL be one combinational sub-module, inst_pack (op and fields in, 32-bit word and illegal flag out).

Verification
REQ-036 Reset, load_addr with start_addr=0x100, ADD rd=3 rn=1 rm=2 -> out_word 0x8B020023, out_addr 0x100.
REQ-037 ADDI rd=1 rn=0 imm=5, then LDUR rd=2 rn=1 imm=8 back-to-back, out_ready=1 -> 0x91001401 @0x100, then 0xF8408022 @0x104, no bubble.
REQ-038 MOVZ rd=0 hw=1 imm=0xABCD with out_ready=0 for 3 cycles -> 0xD2B579A0 held stable, in_ready=0, count unchanged until release.
REQ-039 B imm=0x3FFFFFF -> 0x17FFFFFF; then op=12 -> err=1, no output word, next legal word's address is +4 from B only.
REQ-040 Counter at 2^ADDR_W-4, two legal ops -> addresses 0xFF..FC then 0; resetl low while out_valid=1 -> out_valid=0, err=0, count=0.
